// File: rtl/fetch_predictor.sv
// Fetch-stage next-address selection with a gshare PHT and an optional return address stack.
// Define FETCH_RAS_EN to build the return address stack; without it is_ret always uses ret_addr_in.
module fetch_predictor #(
    parameter int                    ADDR_WIDTH    = 15,
    parameter int                    PATTERN_WIDTH = 10,
    parameter int                    GH_WIDTH      = 4,
    parameter int                    RAS_DEPTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] PC_INIT       = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [ADDR_WIDTH-1:0]    flush_addr,
    input  logic                     is_j,
    input  logic                     is_b,
    input  logic                     is_call,
    input  logic                     is_ret,
    input  logic [ADDR_WIDTH-1:0]    target,
    input  logic [ADDR_WIDTH-1:0]    ret_addr_in,
    input  logic                     commit_b,
    input  logic [PATTERN_WIDTH-1:0] commit_pattern,
    input  logic [1:0]               commit_pred,
    input  logic                     commit_fail,
    output logic [ADDR_WIDTH-1:0]    fetch_addr,
    output logic [ADDR_WIDTH-1:0]    pc,
    output logic [1:0]               pred,
    output logic [PATTERN_WIDTH-1:0] pattern,
    output logic                     ras_empty
);

    if (GH_WIDTH < 1 || GH_WIDTH > PATTERN_WIDTH || RAS_DEPTH < 2 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
        $error("fetch_predictor: illegal parameter combination");
    end

    localparam int PHT_SIZE = 1 << PATTERN_WIDTH;

    logic                     advance;
    logic [GH_WIDTH-1:0]      gh;
    logic [PATTERN_WIDTH-1:0] gh_ext;
    logic [PATTERN_WIDTH-1:0] index;
    logic [1:0]               pht [PHT_SIZE];
    logic [1:0]               pht_wdata;
    logic                     pht_we;
    logic                     taken;
    logic [ADDR_WIDTH-1:0]    ras_top;

    assign advance = flush | ~stall;

    // History occupies the top bits of the index so low address bits still spread entries.
    assign gh_ext = PATTERN_WIDTH'(gh) << (PATTERN_WIDTH - GH_WIDTH);
    assign index  = fetch_addr[PATTERN_WIDTH-1:0] ^ gh_ext;

    assign taken     = commit_pred[1] ^ commit_fail;
    assign pht_wdata = {commit_pred[1] ^ (~commit_pred[0] & commit_fail), ~commit_fail};
    assign pht_we    = commit_b & reset_n;

    // NOTE: fetch_addr gets a default before the priority chain, so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_addr = pc;
        if (flush)
            fetch_addr = flush_addr;
        else if (is_j || is_call)
            fetch_addr = target;
        else if (is_b && pred[1])
            fetch_addr = target;
        else if (is_ret)
            fetch_addr = ras_empty ? ret_addr_in : ras_top;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, e.g. index sees the old gh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= PC_INIT;
            pred    <= 2'b00;
            pattern <= '0;
            gh      <= '0;
        end else begin
            pattern <= index;
            if (advance) begin
                pc   <= fetch_addr + ADDR_WIDTH'(1);
                pred <= pht[index];
            end
            if (commit_b)
                gh <= GH_WIDTH'({gh, taken});
        end
    end

    // NOTE: the PHT is intentionally not reset, so branch training survives a reset_n pulse.
    always_ff @(posedge clk) begin
        if (pht_we)
            pht[commit_pattern] <= pht_wdata;
    end

`ifdef FETCH_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ras_ptr;
    logic [PTR_W-1:0]      top_ptr;
    logic [PTR_W:0]        ras_count;
    logic                  ras_upd;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_repl;

    // ras_ptr is the next free slot; the stack wraps and silently drops the oldest entry.
    assign top_ptr   = ras_ptr - PTR_W'(1);
    assign ras_top   = ras_mem[top_ptr];
    assign ras_empty = (ras_count == '0);

    assign ras_upd = ~flush & ~stall;
    assign do_push = ras_upd & is_call & ~is_ret;
    assign do_pop  = ras_upd & is_ret & ~is_call;
    assign do_repl = ras_upd & is_call & is_ret;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (flush) begin
            ras_count <= '0;
        end else if (do_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_count != (PTR_W + 1)'(RAS_DEPTH))
                ras_count <= ras_count + (PTR_W + 1)'(1);
        end else if (do_pop && !ras_empty) begin
            ras_ptr   <= top_ptr;
            ras_count <= ras_count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[ras_ptr] <= pc;
        else if (do_repl)
            ras_mem[top_ptr] <= pc;
    end
`else
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
`endif

endmodule
